// File: rtl/rgmii_tx_ms_if.sv
// MAC-side transmit bus and DDR pair outputs of the multi-speed RGMII
// transmit formatter. The master is the MAC / pad wrapper side; the slave
// is the formatter.
interface rgmii_tx_ms_if;
    logic [1:0] speed;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] gmii_txd;
    logic       gmii_tx_ready;
    logic [1:0] cur_speed;
    logic       txc_r;
    logic       txc_f;
    logic       ctl_r;
    logic       ctl_f;
    logic [3:0] txd_r;
    logic [3:0] txd_f;

    modport master (
        output speed, gmii_tx_en, gmii_tx_er, gmii_txd,
        input  gmii_tx_ready, cur_speed, txc_r, txc_f, ctl_r, ctl_f, txd_r, txd_f
    );

    modport slave (
        input  speed, gmii_tx_en, gmii_tx_er, gmii_txd,
        output gmii_tx_ready, cur_speed, txc_r, txc_f, ctl_r, ctl_f, txd_r, txd_f
    );
endinterface

// File: rtl/rgmii_tx_ms.sv
// Multi-speed GMII-to-RGMII transmit formatter. Produces rising/falling
// pairs for TXC, TX_CTL and TXD from one 125 MHz clock. At 1000M every
// cycle carries a byte; at 10/100 the block divides the clock itself,
// sends one nibble per TXC period and paces the MAC with gmii_tx_ready.
module rgmii_tx_ms #(
    parameter logic [1:0] DEFAULT_SPEED = 2'b10,
    parameter bit         TXC_INVERT    = 1'b0
) (
    input  logic          gmii_tx_clk,
    input  logic          rst,
    rgmii_tx_ms_if.slave  bus
);

    // Mode / pacing state
    logic [1:0] r_speed;
    logic [5:0] r_cnt;
    logic       r_phase;
    logic       r_ready;

    // Byte held for the two nibble periods at 10/100
    logic [7:0] r_hold_txd;
    logic       r_hold_en;
    logic       r_hold_er;

    // Registered DDR pairs
    logic       r_txc_r, r_txc_f;
    logic       r_ctl_r, r_ctl_f;
    logic [3:0] r_txd_r, r_txd_f;

    logic       w_gig;
    logic [5:0] w_last;
    logic       w_cnt_end;
    logic       w_en;
    logic       w_er;
    logic [7:0] w_byte;
    logic       w_boundary;
    logic       w_byte_en;
    logic       w_change;
    logic       w_txc_r, w_txc_f;
    logic       w_ctl_r, w_ctl_f;
    logic [3:0] w_txd_r, w_txd_f;

    // Both 2'b10 and 2'b11 run at 1000M.
    assign w_gig     = r_speed[1];
    assign w_last    = (r_speed == 2'b01) ? 6'd4 : 6'd49;
    assign w_cnt_end = (r_cnt == w_last);

    // The live MAC inputs only count in the cycle that ready is shown;
    // every other cycle of a slow byte works from the hold register.
    assign w_en   = r_ready ? bus.gmii_tx_en : r_hold_en;
    assign w_er   = r_ready ? bus.gmii_tx_er : r_hold_er;
    assign w_byte = r_ready ? bus.gmii_txd   : r_hold_txd;

    // A speed switch is only taken between bytes, and only if the byte
    // that just finished was idle, so a frame is never split across modes.
    assign w_boundary = w_gig | (w_cnt_end & r_phase);
    assign w_byte_en  = w_gig ? (r_ready & bus.gmii_tx_en) : r_hold_en;
    assign w_change   = w_boundary & ~w_byte_en & (bus.speed != r_speed);

    // Next pair values from the state of the cycle now ending
    always_comb begin
        w_txc_r = 1'b0;
        w_txc_f = 1'b0;
        w_ctl_r = 1'b0;
        w_ctl_f = 1'b0;
        w_txd_r = 4'h0;
        w_txd_f = 4'h0;
        if (w_gig) begin
            w_txc_r = 1'b1;
            w_txc_f = 1'b0;
            if (r_ready) begin
                w_txd_r = bus.gmii_txd[3:0];
                w_txd_f = bus.gmii_txd[7:4];
                w_ctl_r = bus.gmii_tx_en;
                w_ctl_f = bus.gmii_tx_en ^ bus.gmii_tx_er;
            end
        end else begin
            w_txd_r = r_phase ? w_byte[7:4] : w_byte[3:0];
            w_txd_f = w_txd_r;
            w_ctl_r = w_en;
            w_ctl_f = w_en ^ w_er;
            if (r_speed == 2'b01) begin
                // 2.5 cycles high, 2.5 low: the middle cycle splits at the falling half
                w_txc_r = (r_cnt <= 6'd2);
                w_txc_f = (r_cnt <= 6'd1);
            end else begin
                w_txc_r = (r_cnt <= 6'd24);
                w_txc_f = w_txc_r;
            end
        end
    end

    // Speed, nibble counter/phase, ready strobe and byte hold
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            r_speed    <= DEFAULT_SPEED;
            r_cnt      <= 6'd0;
            r_phase    <= 1'b0;
            r_ready    <= 1'b0;
            r_hold_txd <= 8'h00;
            r_hold_en  <= 1'b0;
            r_hold_er  <= 1'b0;
        end else begin
            if (r_ready) begin
                r_hold_txd <= bus.gmii_txd;
                r_hold_en  <= bus.gmii_tx_en;
                r_hold_er  <= bus.gmii_tx_er;
            end
            if (w_change) begin
                r_speed <= bus.speed;
                r_cnt   <= 6'd0;
                r_phase <= 1'b0;
                r_ready <= 1'b1;
            end else if (w_gig) begin
                r_cnt   <= 6'd0;
                r_phase <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                if (w_cnt_end) begin
                    r_cnt   <= 6'd0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
                // Next cycle is cnt 0 / phase 0 only when leaving the last high-nibble count
                r_ready <= w_cnt_end & r_phase;
            end
        end
    end

    // Output pair registers; TXC inversion is applied only outside reset
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            r_txc_r <= 1'b0;
            r_txc_f <= 1'b0;
            r_ctl_r <= 1'b0;
            r_ctl_f <= 1'b0;
            r_txd_r <= 4'h0;
            r_txd_f <= 4'h0;
        end else begin
            r_txc_r <= w_txc_r ^ TXC_INVERT;
            r_txc_f <= w_txc_f ^ TXC_INVERT;
            r_ctl_r <= w_ctl_r;
            r_ctl_f <= w_ctl_f;
            r_txd_r <= w_txd_r;
            r_txd_f <= w_txd_f;
        end
    end

    assign bus.gmii_tx_ready = r_ready;
    assign bus.cur_speed     = r_speed;
    assign bus.txc_r         = r_txc_r;
    assign bus.txc_f         = r_txc_f;
    assign bus.ctl_r         = r_ctl_r;
    assign bus.ctl_f         = r_ctl_f;
    assign bus.txd_r         = r_txd_r;
    assign bus.txd_f         = r_txd_f;

endmodule

// File: tb/tb_rgmii_tx_ms.sv
// Scoreboard bench for rgmii_tx_ms: expected output vectors are queued as
// stimulus is driven and popped one cycle later when the registered pairs
// appear. A second instance with TXC_INVERT=1 shares the same inputs.
// Vector layout: {ready, cur_speed[1:0], txc_r, txc_f, ctl_r, ctl_f, txd_r, txd_f}
module tb_rgmii_tx_ms;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [14:0] exp_q0[$];
    logic [14:0] exp_q1[$];
    logic [14:0] got, exp;

    rgmii_tx_ms_if bus0();
    rgmii_tx_ms_if bus1();

    assign bus1.speed      = bus0.speed;
    assign bus1.gmii_tx_en = bus0.gmii_tx_en;
    assign bus1.gmii_tx_er = bus0.gmii_tx_er;
    assign bus1.gmii_txd   = bus0.gmii_txd;

    rgmii_tx_ms #(.DEFAULT_SPEED(2'b10), .TXC_INVERT(1'b0)) dut0 (
        .gmii_tx_clk(clk), .rst(rst), .bus(bus0.slave));
    rgmii_tx_ms #(.DEFAULT_SPEED(2'b10), .TXC_INVERT(1'b1)) dut1 (
        .gmii_tx_clk(clk), .rst(rst), .bus(bus1.slave));

    always #4 clk = ~clk;

    function automatic logic [14:0] mk(input logic rdy, input logic [1:0] spd,
                                       input logic [1:0] txc, input logic [1:0] ctl,
                                       input logic [3:0] tr, input logic [3:0] tf);
        return {rdy, spd, txc, ctl, tr, tf};
    endfunction

    function automatic logic [14:0] obs0();
        return {bus0.gmii_tx_ready, bus0.cur_speed, bus0.txc_r, bus0.txc_f,
                bus0.ctl_r, bus0.ctl_f, bus0.txd_r, bus0.txd_f};
    endfunction

    function automatic logic [14:0] obs1();
        return {bus1.gmii_tx_ready, bus1.cur_speed, bus1.txc_r, bus1.txc_f,
                bus1.ctl_r, bus1.ctl_f, bus1.txd_r, bus1.txd_f};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus0.speed = 2'b10; bus0.gmii_tx_en = 1'b0; bus0.gmii_tx_er = 1'b0; bus0.gmii_txd = 8'h00;
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            exp_q0.push_back(mk(1'b0, 2'b10, 2'b00, 2'b00, 4'h0, 4'h0));
            exp_q1.push_back(mk(1'b0, 2'b10, 2'b00, 2'b00, 4'h0, 4'h0));
            if (k > 0) step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL reset_state[%0d]: got %h want %h", k, got, exp); end
            got = obs1(); exp = exp_q1.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL reset_state_inv[%0d]: got %h want %h", k, got, exp); end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q0.push_back(mk(1'b1, 2'b10, 2'b10, 2'b00, 4'h0, 4'h0));
            exp_q1.push_back(mk(1'b1, 2'b10, 2'b01, 2'b00, 4'h0, 4'h0));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL post_reset_idle[%0d]: got %h want %h", k, got, exp); end
            got = obs1(); exp = exp_q1.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL post_reset_idle_inv[%0d]: got %h want %h", k, got, exp); end
        end
    endtask

    task automatic test_gig();
        logic [7:0] b;
        for (int i = 0; i < 9; i++) begin
            b = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : 8'h00);
            bus0.gmii_txd = b;
            bus0.gmii_tx_en = (i < 8);
            bus0.gmii_tx_er = 1'b0;
            exp_q0.push_back(mk(1'b1, 2'b10, 2'b10, (i < 8) ? 2'b11 : 2'b00, b[3:0], b[7:4]));
            exp_q1.push_back(mk(1'b1, 2'b10, 2'b01, (i < 8) ? 2'b11 : 2'b00, b[3:0], b[7:4]));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL gig_byte[%0d]: got %h want %h", i, got, exp); end
            got = obs1(); exp = exp_q1.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL gig_inv_byte[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_speed_change();
        logic [7:0] b;
        bus0.speed = 2'b01;
        for (int i = 0; i < 4; i++) begin
            b = (i < 3) ? 8'((i + 1) * 8'h11) : 8'h00;
            bus0.gmii_txd = b;
            bus0.gmii_tx_en = (i < 3);
            if (i < 3) exp_q0.push_back(mk(1'b1, 2'b10, 2'b10, 2'b11, b[3:0], b[7:4]));
            else       exp_q0.push_back(mk(1'b1, 2'b01, 2'b10, 2'b00, 4'h0, 4'h0));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL speed_change[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_100();
        logic [7:0] b;
        logic       e;
        logic [3:0] nib;
        logic [1:0] tx;
        int         m;
        bus0.gmii_txd = 8'hA7; bus0.gmii_tx_en = 1'b1; bus0.gmii_tx_er = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            m   = j - 1;
            b   = (m < 10) ? 8'hA7 : ((m < 20) ? 8'h3C : 8'h00);
            e   = (m < 20);
            nib = ((m % 10) < 5) ? b[3:0] : b[7:4];
            tx  = ((m % 5) < 2) ? 2'b11 : (((m % 5) == 2) ? 2'b10 : 2'b00);
            exp_q0.push_back(mk((j % 10) == 0, (j == 30) ? 2'b00 : 2'b01, tx, {e, e}, nib, nib));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL m100_cycle[%0d]: got %h want %h", j, got, exp); end
            if (j == 10) bus0.gmii_txd = 8'h3C;
            if (j == 20) begin
                bus0.gmii_txd = 8'h00; bus0.gmii_tx_en = 1'b0; bus0.speed = 2'b00;
            end
        end
    endtask

    task automatic test_10();
        logic [3:0] nib;
        logic [1:0] tx;
        int         m;
        bus0.gmii_txd = 8'h96; bus0.gmii_tx_en = 1'b1; bus0.gmii_tx_er = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            m   = j - 1;
            nib = (m < 50) ? 4'h6 : 4'h9;
            tx  = ((m % 50) < 25) ? 2'b11 : 2'b00;
            exp_q0.push_back(mk(j == 100, 2'b00, tx, 2'b10, nib, nib));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL m10_cycle[%0d]: got %h want %h", j, got, exp); end
        end
    endtask

    task automatic test_reset_midframe();
        bus0.gmii_txd = 8'h5A; bus0.gmii_tx_en = 1'b1; bus0.gmii_tx_er = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            exp_q0.push_back(mk(1'b0, 2'b00, 2'b11, 2'b11, 4'hA, 4'hA));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL m10_frame2[%0d]: got %h want %h", j, got, exp); end
        end
        exp_q0.push_back(mk(1'b0, 2'b10, 2'b00, 2'b00, 4'h0, 4'h0));
        exp_q1.push_back(mk(1'b0, 2'b10, 2'b00, 2'b00, 4'h0, 4'h0));
        #2 rst = 1'b1;
        #1;
        got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL async_reset: got %h want %h", got, exp); end
        got = obs1(); exp = exp_q1.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL async_reset_inv: got %h want %h", got, exp); end
        bus0.gmii_txd = 8'h00; bus0.gmii_tx_en = 1'b0; bus0.gmii_tx_er = 1'b0; bus0.speed = 2'b10;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q0.push_back(mk(1'b1, 2'b10, 2'b10, 2'b00, 4'h0, 4'h0));
            step();
            got = obs0(); exp = exp_q0.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL after_reset_release[%0d]: got %h want %h", k, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_gig();
        test_speed_change();
        test_100();
        test_10();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
